stack_tos_unit: RTL
===================

# stack_tos_unit

Parametrised operand-stack engine for the bytecode core, succeeding the single-register TOS block. It caches the top two stack entries (TOS, NOS) in registers and spills deeper entries to an internal synchronous-read stack RAM. It executes one stack micro-op per accepted request under a valid/ready handshake, and tracks depth, full/empty and sticky overflow/underflow errors. The control FSM drives it in place of separate TOS-register and stack-memory controls.

## Interface
- DATA_WIDTH, 8, stack entry width
- ADDR_WIDTH, 12, stack RAM address width
- DEPTH, 4096, maximum entries including TOS/NOS; 3 ≤ DEPTH ≤ 2^ADDR_WIDTH + 2

- clk  in  1  clock; all state updates on posedge
- reset  in  1  asynchronous, active-low reset
- op_valid  in  1  request valid
- op_ready  out  1  unit can accept a request this cycle
- op_code  in  3  000 NOP, 001 PUSH, 010 POP, 011 DUP, 100 SWAP, 101 BINOP, 110 REPLACE, 111 CLEAR
- push_data  in  DATA_WIDTH  operand for PUSH/BINOP/REPLACE
- err_clr  in  1  clears both error flags
- tos_out  out  DATA_WIDTH  cached TOS
- nos_out  out  DATA_WIDTH  cached NOS
- depth_out  out  ADDR_WIDTH+1  current entry count
- empty  out  1  depth_out == 0
- full  out  1  depth_out == DEPTH
- err_overflow  out  1  sticky overflow flag
- err_underflow  out  1  sticky underflow flag

## Operation
- Accept occurs when op_valid && op_ready. Non-accepted cycles change nothing.
- Storage mapping: TOS is valid when depth ≥ 1; NOS is valid when depth ≥ 2. RAM holds entries at addresses 0..depth-3, oldest at 0.
- PUSH: if depth ≥ 2, RAM[depth-2] ← NOS. Then NOS ← TOS, TOS ← push_data, depth+1.
- DUP: same as PUSH with operand TOS.
- POP: TOS ← NOS, depth-1. If the old depth ≥ 3, issue a RAM read of address depth-3 and enter REFILL.
- BINOP (ALU result replaces two operands): as POP, but TOS ← push_data.
- SWAP: TOS ↔ NOS. Depth is unchanged.
- REPLACE: TOS ← push_data. Requires depth ≥ 1.
- CLEAR: depth ← 0. Registers keep their values, which are don't-care.
- FSM states:
  - IDLE: op_ready = 1. A POP or BINOP with old depth ≥ 3 moves to REFILL; all other ops stay in IDLE.
  - REFILL: op_ready = 0. NOS ← RAM read data, then return to IDLE.
- Slots that become invalid hold don't-care contents. tos_out and nos_out are meaningful only while the corresponding slot is valid.
- Error flags are sticky until err_clr or reset. err_clr takes priority over a same-cycle set.

## Timing
- Reset values: op_ready 1, tos_out 0, nos_out 0, depth_out 0, empty 1, full 0, both error flags 0, FSM in IDLE.
- Reset asserted during REFILL aborts it. The unit returns to IDLE with depth 0.
- Latency: all results are visible the cycle after accept.
- POP/BINOP with old depth ≥ 3 have a single-cycle REFILL bubble, so ready is low for exactly one cycle. Throughput is 1 op/cycle otherwise.
- RAM has a 1-cycle synchronous read and a write on the accept edge. A write and a refill read never target the same cycle, because REFILL blocks accept.
- full and empty are combinational from depth_out.

## Configuration
- STACK_TOS_CHECK_EN defined:
  - PUSH or DUP at depth == DEPTH is dropped (no state change) and sets err_overflow.
  - These ops are dropped and set err_underflow: POP, DUP or REPLACE at depth 0; SWAP or BINOP at depth < 2.
  - A dropped op never enters REFILL.
- STACK_TOS_CHECK_EN undefined: no checks are performed. Error flags are tied to 0. depth_out wraps modulo 2^(ADDR_WIDTH+1), and stack contents after misuse are undefined.

## Test plan
- Reset then PUSH 0x11, 0x22, 0x33 → tos 0x33, nos 0x22, depth 3, op_ready stays 1.
- Continuing: POP → next cycle tos 0x22, op_ready 0 for one cycle, then nos 0x11, depth 2, op_ready 1.
- Depth 2 (tos 0x22, nos 0x11): SWAP → tos 0x11, nos 0x22. Then BINOP push_data 0x33 → tos 0x33, depth 1, no REFILL.
- CHECK_EN, DEPTH=4: five PUSHes → depth 4, full 1, err_overflow 1, tos equals the 4th value. err_clr → flag 0.
- CHECK_EN: POP at depth 0 → err_underflow 1, depth 0, empty 1. SWAP at depth 1 → dropped, tos unchanged.
- Reset asserted asynchronously mid-REFILL → outputs at reset values immediately. After release, PUSH 0xAA → tos 0xAA, depth 1.

Source files
------------

// File: rtl/stack_tos_unit.sv
// stack_tos_unit: operand-stack engine caching TOS/NOS in registers and
// spilling deeper entries to a synchronous-read RAM. One micro-op per accept.
// Optional misuse checking (overflow/underflow drop + sticky flags) is
// enabled by defining STACK_TOS_CHECK_EN.
module stack_tos_unit #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 12,
    parameter int DEPTH      = 4096
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  op_valid,
    output logic                  op_ready,
    input  logic [2:0]            op_code,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  err_clr,
    output logic [DATA_WIDTH-1:0] tos_out,
    output logic [DATA_WIDTH-1:0] nos_out,
    output logic [ADDR_WIDTH:0]   depth_out,
    output logic                  empty,
    output logic                  full,
    output logic                  err_overflow,
    output logic                  err_underflow
);

    localparam int CW = ADDR_WIDTH + 1;

    localparam logic [2:0] OP_NOP     = 3'b000;
    localparam logic [2:0] OP_PUSH    = 3'b001;
    localparam logic [2:0] OP_POP     = 3'b010;
    localparam logic [2:0] OP_DUP     = 3'b011;
    localparam logic [2:0] OP_SWAP    = 3'b100;
    localparam logic [2:0] OP_BINOP   = 3'b101;
    localparam logic [2:0] OP_REPLACE = 3'b110;
    localparam logic [2:0] OP_CLEAR   = 3'b111;

    typedef enum logic {S_IDLE, S_REFILL} state_e;

    state_e                  state, state_nxt;
    logic [DATA_WIDTH-1:0]   tos, nos;
    logic [CW-1:0]           depth;
    logic [DATA_WIDTH-1:0]   mem [0:(2**ADDR_WIDTH)-1];
    logic [DATA_WIDTH-1:0]   rd_data;

    logic                    accept, drop, do_op;
    logic                    ovf_set, unf_set;
    logic                    is_push, is_pop;
    logic                    ram_we, ram_re;
    logic [CW-1:0]           wr_slot, rd_slot;
    logic [ADDR_WIDTH-1:0]   wr_addr, rd_addr;

    // REFILL blocks new requests so the refill read never collides with a spill.
    assign op_ready = (state == S_IDLE);
    assign accept   = op_valid && op_ready;

    assign is_push  = (op_code == OP_PUSH) || (op_code == OP_DUP);
    assign is_pop   = (op_code == OP_POP)  || (op_code == OP_BINOP);

    // Misuse detection: a flagged op is dropped entirely.
    always_comb begin
        ovf_set = 1'b0;
        unf_set = 1'b0;
`ifdef STACK_TOS_CHECK_EN
        if (accept) begin
            case (op_code)
                OP_PUSH:            ovf_set = (depth == CW'(DEPTH));
                OP_DUP: begin
                    unf_set = (depth == '0);
                    ovf_set = (depth == CW'(DEPTH));
                end
                OP_POP, OP_REPLACE: unf_set = (depth == '0);
                OP_SWAP, OP_BINOP:  unf_set = (depth < CW'(2));
                default: ;
            endcase
        end
`endif
    end

    assign drop  = ovf_set || unf_set;
    assign do_op = accept && !drop;

    // NOS spills to the slot just above the RAM-resident entries; a pop
    // refills NOS from the newest RAM entry.
    assign wr_slot = depth - CW'(2);
    assign rd_slot = depth - CW'(3);
    assign wr_addr = wr_slot[ADDR_WIDTH-1:0];
    assign rd_addr = rd_slot[ADDR_WIDTH-1:0];
    assign ram_we  = do_op && is_push && (depth >= CW'(2));
    assign ram_re  = do_op && is_pop  && (depth >= CW'(3));

    // Stack RAM: write on the accept edge, one-cycle synchronous read.
    always_ff @(posedge clk) begin
        if (ram_we) mem[wr_addr] <= nos;
        if (ram_re) rd_data <= mem[rd_addr];
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // FSM next state: a pop reaching into RAM costs one refill cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (ram_re) state_nxt = S_REFILL;
            S_REFILL: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // TOS/NOS/depth update for each executed micro-op, plus NOS refill.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tos   <= '0;
            nos   <= '0;
            depth <= '0;
        end else begin
            if (state == S_REFILL) nos <= rd_data;
            if (do_op) begin
                case (op_code)
                    OP_PUSH: begin
                        nos   <= tos;
                        tos   <= push_data;
                        depth <= depth + CW'(1);
                    end
                    OP_DUP: begin
                        nos   <= tos;
                        depth <= depth + CW'(1);
                    end
                    OP_POP: begin
                        tos   <= nos;
                        depth <= depth - CW'(1);
                    end
                    OP_BINOP: begin
                        tos   <= push_data;
                        depth <= depth - CW'(1);
                    end
                    OP_SWAP: begin
                        tos <= nos;
                        nos <= tos;
                    end
                    OP_REPLACE: tos   <= push_data;
                    OP_CLEAR:   depth <= '0;
                    OP_NOP:     ;
                    default:    ;
                endcase
            end
        end
    end

    // Sticky error flags; clear wins over a same-cycle set. Without checking
    // the set terms are constant 0 so the flags never leave reset value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
        end else if (err_clr) begin
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            if (ovf_set) err_overflow  <= 1'b1;
            if (unf_set) err_underflow <= 1'b1;
        end
    end

    assign tos_out   = tos;
    assign nos_out   = nos;
    assign depth_out = depth;
    assign empty     = (depth == '0);
    assign full      = (depth == CW'(DEPTH));

endmodule
